// File: rtl/alu_op_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_issuer_if
// Description : Bundle of the request, ALU-drive and response signals of the
//               ALU operation issuer.
//                 slave  - the issuer itself (accepts requests, drives ALU,
//                          returns responses)
//                 master - the environment (sequencer, ALU slice, consumer)
//               Signals: req_valid/req_ready/req_a/req_b/req_opcode/req_tag,
//               alu_a/alu_b/alu_opcode/alu_en/alu_result,
//               rsp_valid/rsp_ready/rsp_result/rsp_tag/rsp_err, count.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_issuer_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
);
    localparam int c_cw = $clog2(DEPTH + 1);

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [OPW-1:0]   req_opcode;
    logic [TAG_W-1:0] req_tag;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_opcode;
    logic             alu_en;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [c_cw-1:0]  count;

    modport slave (
        input  req_valid, req_a, req_b, req_opcode, req_tag, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_opcode, alu_en,
               rsp_valid, rsp_result, rsp_tag, rsp_err, count
    );

    modport master (
        output req_valid, req_a, req_b, req_opcode, req_tag, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_opcode, alu_en,
               rsp_valid, rsp_result, rsp_tag, rsp_err, count
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_issuer
// Description : Initiator side of a combinational ALU slice. Accepts
//               operation requests, registers them in a single issue stage
//               that drives the ALU, captures the ALU result one cycle later
//               and returns it with its tag through an in-order response FIFO.
//               Opcodes not enabled in OP_MASK never reach the ALU; they
//               return rsp_err = 1 with a zero result.
//   Ports     : clk    - clock, all state on the rising edge
//               rst_n  - synchronous active-low reset
//               bus    - alu_op_issuer_if.slave (request, ALU, response, count)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_issuer #(
    parameter int                   WIDTH   = 32,
    parameter int                   OPW     = 3,
    parameter int                   TAG_W   = 4,
    parameter int                   DEPTH   = 4,
    parameter logic [(2**OPW)-1:0]  OP_MASK = 8'b0000_0010
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_op_issuer_if.slave    bus
);
    localparam int             c_aw    = $clog2(DEPTH);
    localparam int             c_cw    = $clog2(DEPTH + 1);
    localparam logic [c_cw:0]  c_depth = (c_cw + 1)'(DEPTH);

    // Issue stage
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [OPW-1:0]   s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_legal_q, s1_legal_d;

    // Response FIFO
    logic [WIDTH-1:0] mem_result_q [DEPTH];
    logic [TAG_W-1:0] mem_tag_q    [DEPTH];
    logic             mem_err_q    [DEPTH];
    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]  count_q, count_d;

    // Registered head-of-FIFO view
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_err_q, rsp_err_d;

    logic             w_req_ready;
    logic             w_req_fire;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_push_result;
    logic [c_cw-1:0]  w_remaining;

    always_comb begin
        // Occupancy counts the issue stage too, so the capture that follows
        // an accept always finds a free FIFO slot.
        w_req_ready   = rst_n & (({1'b0, count_q} + {{c_cw{1'b0}}, s1_valid_q}) < c_depth);
        w_req_fire    = bus.req_valid & w_req_ready;
        w_push        = s1_valid_q;
        w_pop         = (count_q != '0) & bus.rsp_ready;
        w_push_result = s1_legal_q ? bus.alu_result : '0;

        s1_valid_d = w_req_fire;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        s1_legal_d = s1_legal_q;
        if (w_req_fire) begin
            s1_a_d     = bus.req_a;
            s1_b_d     = bus.req_b;
            s1_op_d    = bus.req_opcode;
            s1_tag_d   = bus.req_tag;
            s1_legal_d = OP_MASK[bus.req_opcode];
        end

        wr_ptr_d = w_push ? wr_ptr_q + c_aw'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + c_aw'(1) : rd_ptr_q;

        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cw'(1);
            2'b01:   count_d = count_q - c_cw'(1);
            default: count_d = count_q;
        endcase

        // Entries that were already stored and survive this edge's pop.
        w_remaining = w_pop ? count_q - c_cw'(1) : count_q;

        // Next head: an older stored entry if one remains, otherwise the
        // entry being captured now; with neither, the last head is held.
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;
        if (w_remaining != '0) begin
            rsp_result_d = mem_result_q[rd_ptr_d];
            rsp_tag_d    = mem_tag_q[rd_ptr_d];
            rsp_err_d    = mem_err_q[rd_ptr_d];
        end else if (w_push) begin
            rsp_result_d = w_push_result;
            rsp_tag_d    = s1_tag_q;
            rsp_err_d    = ~s1_legal_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= '0;
            s1_tag_q     <= '0;
            s1_legal_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_tag_q     <= s1_tag_d;
            s1_legal_q   <= s1_legal_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written,
    // because count and the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_result_q[wr_ptr_q] <= w_push_result;
            mem_tag_q[wr_ptr_q]    <= s1_tag_q;
            mem_err_q[wr_ptr_q]    <= ~s1_legal_q;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.alu_a      = s1_a_q;
    assign bus.alu_b      = s1_b_q;
    assign bus.alu_opcode = s1_legal_q ? s1_op_q : '0;
    assign bus.alu_en     = s1_valid_q & s1_legal_q;
    assign bus.rsp_valid  = (count_q != '0);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.count      = count_q;

endmodule
`default_nettype wire
